// File: rtl/grand_adder_pipe.sv
// FMA final adder: merges the product CSA pair with the aligned addend and produces
// the positive magnitude, sign, LZA operands, minus-sticky and special-case flags.
module grand_adder_pipe #(
  parameter int PARM_EXP    = 8,
  parameter int PARM_MANT   = 23,
  parameter int PARM_STAGES = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic [2*PARM_MANT+1:0]    CSA_sum_i,
  input  logic [2*PARM_MANT+1:0]    CSA_carry_i,
  input  logic [3*PARM_MANT+4:0]    Addend_i,
  input  logic                      Sub_i,
  input  logic                      Sign_aligned_i,
  input  logic                      Exp_mv_sign_i,
  input  logic                      Sticky_i,
  input  logic [PARM_EXP+1:0]       Exp_i,
  input  logic                      B_Inf_i,
  input  logic                      C_Inf_i,
  input  logic                      B_Zero_i,
  input  logic                      C_Zero_i,
  input  logic                      B_NaN_i,
  input  logic                      C_NaN_i,
  output logic                      valid_o,
  output logic [3*PARM_MANT+4:0]    PosSum_o,
  output logic                      Sign_o,
  output logic [3*PARM_MANT+4:0]    A_LZA_o,
  output logic [3*PARM_MANT+4:0]    B_LZA_o,
  output logic                      Minus_sticky_bit_o,
  output logic                      Sign_change_o,
  output logic [PARM_EXP+1:0]       Exp_o,
  output logic                      NaN_o,
  output logic                      Inf_o,
  output logic                      Zero_o
);
  localparam int PW = 2*PARM_MANT+2;
  localparam int W  = 3*PARM_MANT+5;
  localparam int LW = (W+1)/2;
  localparam int HW = W-LW;
  localparam int EW = PARM_EXP+2;

  // Flow control: an op is accepted on any edge where valid_i=1 and stall_i=0,
  // flush_i=0, rst_i=0. There is no backpressure; stall_i freezes every register
  // and flush_i clears every valid bit (flush wins over stall).

  // Low half of every sum is resolved up front; the high half is finished later.
  typedef struct packed {
    logic          valid;
    logic [W-1:0]  addend;
    logic [HW-1:0] s_hi;
    logic [HW-1:0] c_hi;
    logic [LW-1:0] r_lo;
    logic [LW-1:0] b_lo;
    logic          p_c;
    logic          r_c;
    logic          b_c;
    logic          sub;
    logic          sign_al;
    logic          msb;
    logic          nan;
    logic          inf;
    logic [EW-1:0] exp;
  } front_t;

  front_t        fa, fb;
  logic [W-1:0]  s_ext, c_ext;
  logic [LW:0]   p_lo_x, r_lo_x, b_lo_x;

  assign s_ext  = Exp_mv_sign_i ? '0 : {{(W-PW){1'b0}}, CSA_sum_i};
  assign c_ext  = Exp_mv_sign_i ? '0 : {{(W-PW){1'b0}}, CSA_carry_i};
  assign p_lo_x = {1'b0, s_ext[LW-1:0]} + {1'b0, c_ext[LW-1:0]};
  assign r_lo_x = {1'b0, Addend_i[LW-1:0]} + {1'b0, p_lo_x[LW-1:0]} + {{LW{1'b0}}, Sub_i};
  assign b_lo_x = {1'b0, p_lo_x[LW-1:0]} + {{LW{1'b0}}, Sub_i};

  always_comb begin
    fa         = '0;
    fa.valid   = valid_i;
    fa.addend  = Addend_i;
    fa.s_hi    = s_ext[W-1:LW];
    fa.c_hi    = c_ext[W-1:LW];
    fa.r_lo    = r_lo_x[LW-1:0];
    fa.b_lo    = b_lo_x[LW-1:0];
    fa.p_c     = p_lo_x[LW];
    fa.r_c     = r_lo_x[LW];
    fa.b_c     = b_lo_x[LW];
    fa.sub     = Sub_i;
    fa.sign_al = Sign_aligned_i;
    fa.msb     = Sub_i & (Sticky_i | (Exp_mv_sign_i & ((|CSA_sum_i) | (|CSA_carry_i))));
    fa.nan     = B_NaN_i | C_NaN_i | (B_Inf_i & C_Zero_i) | (C_Inf_i & B_Zero_i);
    fa.inf     = (B_Inf_i | C_Inf_i) & ~fa.nan;
    fa.exp     = Exp_i;
  end

  generate
    if (PARM_STAGES == 1) begin : g_one
      assign fb = fa;
    end else if (PARM_STAGES == 2) begin : g_two
      front_t fr;
      always_ff @(posedge clk_i) begin
        if (rst_i)         fr       <= '0;
        else if (flush_i)  fr.valid <= 1'b0;
        else if (!stall_i) fr       <= fa;
      end
      assign fb = fr;
    end else begin : g_bad
      $error("grand_adder_pipe: PARM_STAGES must be 1 or 2");
    end
  endgenerate

  logic [HW-1:0] p_hi, r_hi, b_hi;
  logic [W-1:0]  r_full, pos_full;
  logic          sc;

  assign p_hi     = fb.s_hi + fb.c_hi + {{(HW-1){1'b0}}, fb.p_c};
  assign r_hi     = fb.addend[W-1:LW] + p_hi + {{(HW-1){1'b0}}, fb.r_c};
  assign b_hi     = p_hi + {{(HW-1){1'b0}}, fb.b_c};
  assign r_full   = {r_hi, fb.r_lo};
  assign sc       = fb.sub & r_full[W-1];
  assign pos_full = sc ? (~r_full + {{(W-1){1'b0}}, 1'b1}) : r_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o            <= 1'b0;
      PosSum_o           <= '0;
      Sign_o             <= 1'b0;
      A_LZA_o            <= '0;
      B_LZA_o            <= '0;
      Minus_sticky_bit_o <= 1'b0;
      Sign_change_o      <= 1'b0;
      Exp_o              <= '0;
      NaN_o              <= 1'b0;
      Inf_o              <= 1'b0;
      Zero_o             <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (!stall_i) begin
      valid_o            <= fb.valid;
      PosSum_o           <= pos_full;
      Sign_o             <= fb.sign_al ^ sc;
      A_LZA_o            <= fb.addend;
      B_LZA_o            <= {b_hi, fb.b_lo};
      Minus_sticky_bit_o <= fb.msb;
      Sign_change_o      <= sc;
      Exp_o              <= fb.exp;
      NaN_o              <= fb.nan;
      Inf_o              <= fb.inf;
      Zero_o             <= ~fb.nan & ~fb.inf & (pos_full == '0);
    end
  end
endmodule
